vga_row_fetch: RTL and testbench

- Supply side of the VGA pixel-word interface: keeps `pixel_row` loaded with the next 16-bit word of a 1 bpp 800x600 bitmap.
- Advances to the following word on each `newData` pulse from the VGA timing generator.
- Fetches words from video memory over a single-outstanding req/ack port into a small prefetch FIFO.
- Resynchronises to the timing generator once per frame. Sits between the video RAM arbiter and the VGA timing block, in the `CLK_VGA` domain.

---
 rtl/vga_row_fetch_if.sv | 12 +
 rtl/vga_row_fetch.sv | 104 ++++++++++
 tb/tb_vga_row_fetch.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_row_fetch_if.sv
// Video-memory read port: single-outstanding request/acknowledge with read data valid on the ack cycle.
interface vga_row_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/vga_row_fetch.sv
// Keeps pixel_row loaded with the next 16-pixel word of a 1 bpp bitmap, prefetching from video memory
// into a small FIFO and realigning to the VGA timing generator at each frame boundary.
module vga_row_fetch #(
  parameter int                WORDS_PER_LINE = 50,
  parameter int                LINES          = 600,
  parameter int                ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int                FIFO_DEPTH     = 4
) (
  input  logic            CLK_VGA,
  input  logic            reset,
  input  logic            newData,
  input  logic            end_of_line,
  input  logic            end_of_frame,
  output logic [15:0]     pixel_row,
  output logic            underrun,
  vga_row_fetch_if.master mem
);
  localparam int               TOTAL = WORDS_PER_LINE * LINES;
  localparam int               CNT_W = $clog2(TOTAL);
  localparam int               PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
  localparam logic [PTR_W:0]   DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state, state_nxt;
  logic [15:0]       fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    occ;
  logic [CNT_W-1:0]  fetch_cnt, pop_cnt, fetch_base;
  logic              discard;
  logic [ADDR_W-1:0] req_addr;
  logic              resync, ack, push, pop, start_req;

  // A frame event only acts when the pop position has not returned to word 0 on its own.
  assign resync     = end_of_line && end_of_frame && (pop_cnt != '0);
  assign ack        = (state == REQ) && mem.mem_ack;
  assign push       = ack && !discard && !resync;
  assign pop        = newData && !resync && (occ != '0);
  assign fetch_base = resync ? '0 : fetch_cnt;

  always_comb begin
    state_nxt = state;
    start_req = 1'b0;
    case (state)
      IDLE: if (occ < DEPTH) begin
        state_nxt = REQ;
        start_req = 1'b1;
      end
      REQ: if (mem.mem_ack) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_VGA or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      fetch_cnt <= '0;
      pop_cnt   <= '0;
      discard   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (resync) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        occ       <= '0;
        fetch_cnt <= '0;
        pop_cnt   <= newData ? CNT_W'(1) : '0;
      end else begin
        if (push) begin
          wr_ptr    <= wr_ptr + PTR_W'(1);
          fetch_cnt <= (fetch_cnt == LAST) ? '0 : fetch_cnt + CNT_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   occ <= occ + (PTR_W + 1)'(1);
          2'b01:   occ <= occ - (PTR_W + 1)'(1);
          default: occ <= occ;
        endcase
        // An empty-FIFO newData still advances the frame position so later words stay aligned.
        if (newData) begin
          pop_cnt <= (pop_cnt == LAST) ? '0 : pop_cnt + CNT_W'(1);
          if (occ == '0) underrun <= 1'b1;
        end
      end
      // A request caught in flight by a resync completes, but its data belongs to the old position.
      if (ack) discard <= 1'b0;
      else if (resync && (state == REQ)) discard <= 1'b1;
    end
  end

  always_ff @(posedge CLK_VGA) begin
    if (push) fifo[wr_ptr] <= mem.mem_rdata;
    if (start_req) req_addr <= BASE_ADDR + ADDR_W'(fetch_base);
  end

  assign mem.mem_req  = (state == REQ);
  assign mem.mem_addr = (state == REQ) ? req_addr : BASE_ADDR + ADDR_W'(fetch_cnt);
  assign pixel_row    = (occ != '0) ? fifo[rd_ptr] : 16'h0000;
endmodule

// File: tb/tb_vga_row_fetch.sv
// Directed/randomized bench for vga_row_fetch on a reduced 8x6-word frame whose base address wraps at 2^16.
module tb_vga_row_fetch;
  localparam int          WPL    = 8;
  localparam int          LNS    = 6;
  localparam int          TOTAL  = WPL * LNS;
  localparam int          ADDR_W = 16;
  localparam logic [15:0] BASE   = 16'hFFF8;
  localparam int          DEPTH  = 4;

  logic        CLK_VGA = 1'b0;
  logic        reset = 1'b0;
  logic        newData = 1'b0;
  logic        end_of_line = 1'b0;
  logic        end_of_frame = 1'b0;
  logic [15:0] pixel_row;
  logic        underrun;

  vga_row_fetch_if #(.ADDR_W(ADDR_W)) mem ();

  vga_row_fetch #(
    .WORDS_PER_LINE(WPL), .LINES(LNS), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK_VGA(CLK_VGA), .reset(reset), .newData(newData), .end_of_line(end_of_line),
    .end_of_frame(end_of_frame), .pixel_row(pixel_row), .underrun(underrun), .mem(mem)
  );

  always #5 CLK_VGA = ~CLK_VGA;

  int          errors = 0;
  int          checks = 0;
  int          lat = 0;
  int          lat_max = 0;
  int          wcnt = 0;
  int          exp_fetch = 0;
  int          pos = 0;
  bit          hold = 1'b0;
  bit          auto_mem = 1'b1;
  bit          chk_fetch = 1'b0;
  logic [15:0] acked [$];

  // Memory contents: an invertible scramble of the address so every word is distinguishable.
  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a ^ 16'h5555;
  endfunction

  function automatic logic [15:0] addr_of(input int idx);
    return BASE + 16'(idx);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: pulses are seen on the edge, cleared after it, and the memory reacts to the new state.
  task automatic step();
    @(posedge CLK_VGA);
    #1;
    newData = 1'b0;
    end_of_line = 1'b0;
    end_of_frame = 1'b0;
    if (mem.mem_ack) begin
      mem.mem_ack = 1'b0;
    end else if (auto_mem && mem.mem_req && !hold) begin
      if (wcnt >= lat) begin
        wcnt = 0;
        mem.mem_ack = 1'b1;
        mem.mem_rdata = word_of(mem.mem_addr);
        acked.push_back(mem.mem_addr);
        if (chk_fetch) begin
          check("fetch_addr", 32'(mem.mem_addr), 32'(addr_of(exp_fetch)));
          exp_fetch = (exp_fetch + 1) % TOTAL;
        end
        lat = $urandom_range(0, lat_max);
      end else begin
        wcnt++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_nd();
    newData = 1'b1;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem.mem_ack = 1'b0;
    wcnt = 0;
    acked.delete();
    exp_fetch = 0;
    pos = 0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    mem.mem_ack = 1'b0;
    mem.mem_rdata = 16'h0000;

    // Reset values
    step();
    step();
    check("rst_pixel_row", pixel_row, 16'h0000);
    check("rst_mem_req", mem.mem_req, 1'b0);
    check("rst_mem_addr", mem.mem_addr, BASE);
    check("rst_underrun", underrun, 1'b0);

    // Zero-wait memory: fill, hold off when full, advance on newData
    lat_max = 0;
    lat = 0;
    chk_fetch = 1'b1;
    reset = 1'b1;
    idle(20);
    check("fill_acks", acked.size(), 4);
    check("full_no_req", mem.mem_req, 1'b0);
    check("head_word0", pixel_row, word_of(BASE));
    pulse_nd();
    check("head_word1", pixel_row, word_of(addr_of(1)));
    idle(10);
    check("refill_acks", acked.size(), 5);
    check("refull_no_req", mem.mem_req, 1'b0);

    // Three frames with random ack latency and random newData spacing
    lat_max = 3;
    lat = 3;
    do_reset();
    idle(20);
    for (int fr = 0; fr < 3; fr++) begin
      for (int ln = 0; ln < LNS; ln++) begin
        for (int w = 0; w < WPL; w++) begin
          idle($urandom_range(5, 9));
          check("pixel_word", pixel_row, word_of(addr_of(pos)));
          pulse_nd();
          pos = (pos + 1) % TOTAL;
        end
        idle(2);
        end_of_line = 1'b1;
        end_of_frame = (ln == LNS - 1);
        step();
      end
      idle($urandom_range(10, 30));
    end
    check("frames_no_underrun", underrun, 1'b0);
    check("frames_fetch_count", acked.size() >= 3 * TOTAL, 1'b1);

    // Withheld memory: underrun, then a misaligned frame event flushes and restarts at BASE
    chk_fetch = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 12; i++) begin
      idle(7);
      pulse_nd();
    end
    check("underrun_set", underrun, 1'b1);
    check("empty_row", pixel_row, 16'h0000);
    hold = 1'b0;
    idle(10);
    for (int i = 0; i < 3; i++) begin
      pulse_nd();
      idle(7);
    end
    end_of_line = 1'b1;
    end_of_frame = 1'b1;
    step();
    check("flush_row", pixel_row, 16'h0000);
    idle(30);
    check("resync_first_word", pixel_row, word_of(BASE));
    check("underrun_sticky", underrun, 1'b1);

    // Asynchronous reset while a request is outstanding
    hold = 1'b1;
    pulse_nd();
    begin
      int n;
      n = 0;
      while (!mem.mem_req && n < 20) begin
        step();
        n++;
      end
    end
    check("req_before_reset", mem.mem_req, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    check("async_mem_req", mem.mem_req, 1'b0);
    check("async_mem_addr", mem.mem_addr, BASE);
    check("async_pixel_row", pixel_row, 16'h0000);
    check("async_underrun", underrun, 1'b0);
    mem.mem_ack = 1'b0;
    hold = 1'b0;
    wcnt = 0;
    acked.delete();
    exp_fetch = 0;
    chk_fetch = 1'b1;
    lat_max = 0;
    lat = 0;
    step();
    reset = 1'b1;
    idle(25);
    check("restart_first_addr", acked[0], BASE);
    check("restart_row", pixel_row, word_of(BASE));

    // Frame event while the request for word 7 is outstanding
    for (int i = 0; i < 3; i++) begin
      pulse_nd();
      idle(6);
    end
    hold = 1'b1;
    pulse_nd();
    idle(3);
    check("req7_pending", mem.mem_req, 1'b1);
    check("req7_addr", mem.mem_addr, addr_of(7));
    chk_fetch = 1'b0;
    end_of_line = 1'b1;
    end_of_frame = 1'b1;
    step();
    check("resync_req_held", mem.mem_req, 1'b1);
    check("resync_addr_held", mem.mem_addr, addr_of(7));
    check("resync_row_zero", pixel_row, 16'h0000);
    idle(5);
    check("resync_addr_still", mem.mem_addr, addr_of(7));
    acked.delete();
    hold = 1'b0;
    idle(20);
    check("discarded_ack_addr", acked[0], addr_of(7));
    check("refill_start_addr", acked[1], BASE);
    check("refill_row", pixel_row, word_of(BASE));

    // Hand-timed acks: no bypass on an empty FIFO, and push+pop with two entries
    auto_mem = 1'b0;
    do_reset();
    step();
    check("manual_req0", mem.mem_req, 1'b1);
    check("manual_addr0", mem.mem_addr, BASE);
    newData = 1'b1;
    mem.mem_ack = 1'b1;
    mem.mem_rdata = word_of(mem.mem_addr);
    step();
    check("nobypass_underrun", underrun, 1'b1);
    check("nobypass_head", pixel_row, word_of(BASE));
    step();
    mem.mem_ack = 1'b1;
    mem.mem_rdata = word_of(mem.mem_addr);
    step();
    step();
    check("manual_addr2", mem.mem_addr, addr_of(2));
    newData = 1'b1;
    mem.mem_ack = 1'b1;
    mem.mem_rdata = word_of(mem.mem_addr);
    step();
    check("pushpop_head", pixel_row, word_of(addr_of(1)));
    pulse_nd();
    check("pushpop_second", pixel_row, word_of(addr_of(2)));
    pulse_nd();
    check("pushpop_empty", pixel_row, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
